// File: rtl/cms_ctrl_sequencer.sv
// rtl/cms_ctrl_sequencer.sv - round-robin host/trigger arbiter, write FIFO and control-port strobe sequencer
module cms_ctrl_sequencer #(
    parameter int CTRL_ADDR_WIDTH = 8,
    parameter int CTRL_DATA_WIDTH = 64,
    parameter int FIFO_DEPTH      = 4,
    parameter int WE_HIGH_CYCLES  = 2,
    parameter int WE_GAP_CYCLES   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         host_valid,
    output logic                         host_ready,
    input  logic [CTRL_ADDR_WIDTH-1:0]   host_addr,
    input  logic [CTRL_DATA_WIDTH-1:0]   host_wdata,
    input  logic                         trig_valid,
    output logic                         trig_ready,
    input  logic [CTRL_ADDR_WIDTH-1:0]   trig_addr,
    input  logic [CTRL_DATA_WIDTH-1:0]   trig_wdata,
    output logic [CTRL_ADDR_WIDTH-1:0]   ctrl_addr,
    output logic [CTRL_DATA_WIDTH-1:0]   ctrl_wdata,
    output logic                         ctrl_write_enable,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [31:0]                  writes_issued
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = CTRL_ADDR_WIDTH + CTRL_DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_GAP} state_t;

    state_t                      r_state;
    logic [31:0]                 r_cnt;
    logic [CTRL_ADDR_WIDTH-1:0]  r_ctrl_addr;
    logic [CTRL_DATA_WIDTH-1:0]  r_ctrl_wdata;
    logic                        r_we;
    logic                        r_busy;
    logic [31:0]                 r_writes_issued;

    logic [EW-1:0]               r_mem [FIFO_DEPTH];
    logic [AW-1:0]               r_wr_ptr;
    logic [AW-1:0]               r_rd_ptr;
    logic [AW:0]                 r_count;
    logic                        r_rr_ptr;

    logic                        w_full;
    logic                        w_empty;
    logic                        w_grant_host;
    logic                        w_grant_trig;
    logic                        w_push_host;
    logic                        w_push_trig;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_gap_last;
    logic                        w_fsm_to_idle;
    logic [EW-1:0]               w_push_data;
    logic [EW-1:0]               w_head;
    logic [AW:0]                 w_count_next;

    assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);

    // Pointer low favours host, high favours trigger; it only matters when both request.
    assign w_grant_host = host_valid && (!trig_valid || !r_rr_ptr);
    assign w_grant_trig = trig_valid && (!host_valid || r_rr_ptr);
    assign host_ready   = w_grant_host && !w_full;
    assign trig_ready   = w_grant_trig && !w_full;
    assign w_push_host  = host_valid && host_ready;
    assign w_push_trig  = trig_valid && trig_ready;
    assign w_push       = w_push_host || w_push_trig;
    assign w_push_data  = w_push_host ? {host_addr, host_wdata} : {trig_addr, trig_wdata};
    assign w_head       = r_mem[r_rd_ptr];

    assign w_gap_last    = (r_state == S_GAP) && (r_cnt == 32'(WE_GAP_CYCLES - 1));
    assign w_pop         = !w_empty && ((r_state == S_IDLE) || w_gap_last);
    assign w_fsm_to_idle = !w_pop && ((r_state == S_IDLE) || w_gap_last);

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rr_ptr <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            if (w_push_host)      r_rr_ptr <= 1'b1;
            else if (w_push_trig) r_rr_ptr <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_ctrl_addr     <= '0;
            r_ctrl_wdata    <= '0;
            r_we            <= 1'b0;
            r_busy          <= 1'b0;
            r_writes_issued <= '0;
        end else begin
            r_busy <= (w_count_next != '0) || !w_fsm_to_idle;
            if (w_pop) begin
                r_ctrl_addr  <= w_head[EW-1 -: CTRL_ADDR_WIDTH];
                r_ctrl_wdata <= w_head[CTRL_DATA_WIDTH-1:0];
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop) r_state <= S_SETUP;
                end
                S_SETUP: begin
                    r_state         <= S_STROBE;
                    r_we            <= 1'b1;
                    r_cnt           <= '0;
                    r_writes_issued <= r_writes_issued + 32'd1;
                end
                S_STROBE: begin
                    if (r_cnt == 32'(WE_HIGH_CYCLES - 1)) begin
                        r_state <= S_GAP;
                        r_we    <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_GAP: begin
                    if (w_gap_last) r_state <= w_pop ? S_SETUP : S_IDLE;
                    else            r_cnt   <= r_cnt + 32'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ctrl_addr         = r_ctrl_addr;
    assign ctrl_wdata        = r_ctrl_wdata;
    assign ctrl_write_enable = r_we;
    assign busy              = r_busy;
    assign fifo_level        = r_count;
    assign writes_issued     = r_writes_issued;
endmodule

// File: tb/tb_cms_ctrl_sequencer.sv
// tb/tb_cms_ctrl_sequencer.sv - scoreboard bench for cms_ctrl_sequencer
module tb_cms_ctrl_sequencer;
    typedef struct packed {
        logic [7:0]  a;
        logic [63:0] d;
    } item_t;

    logic        clk;
    logic        rst_n;
    logic        host_valid;
    logic        host_ready;
    logic [7:0]  host_addr;
    logic [63:0] host_wdata;
    logic        trig_valid;
    logic        trig_ready;
    logic [7:0]  trig_addr;
    logic [63:0] trig_wdata;
    logic [7:0]  ctrl_addr;
    logic [63:0] ctrl_wdata;
    logic        ctrl_write_enable;
    logic        busy;
    logic [2:0]  fifo_level;
    logic [31:0] writes_issued;

    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    logic  prev_we = 1'b0;
    bit    ptr_m = 1'b0;
    bit    saw_full = 1'b0;
    item_t exp_q[$];
    item_t hq[$];
    item_t tq[$];
    bit    order_q[$];
    int    rise_cycles[$];

    cms_ctrl_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr), .host_wdata(host_wdata),
        .trig_valid(trig_valid), .trig_ready(trig_ready), .trig_addr(trig_addr), .trig_wdata(trig_wdata),
        .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata), .ctrl_write_enable(ctrl_write_enable),
        .busy(busy), .fifo_level(fifo_level), .writes_issued(writes_issued)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ctrl_write_enable && !prev_we) begin
            item_t it;
            rise_cycles.push_back(cyc);
            check("rise_has_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                it = exp_q.pop_front();
                check("rise_addr", 64'(ctrl_addr), 64'(it.a));
                check("rise_data", ctrl_wdata, it.d);
            end
        end
        prev_we = ctrl_write_enable;
    end

    // Presents queued host/trig items each cycle and checks ready against a bench arbitration model.
    task automatic run_streams(input int budget);
        int  n = 0;
        bit  eh, et;
        while ((hq.size() != 0 || tq.size() != 0) && n < budget) begin
            host_valid = (hq.size() != 0);
            trig_valid = (tq.size() != 0);
            if (host_valid) begin host_addr = hq[0].a; host_wdata = hq[0].d; end
            if (trig_valid) begin trig_addr = tq[0].a; trig_wdata = tq[0].d; end
            #1;
            eh = host_valid && (!trig_valid || !ptr_m) && (fifo_level < 3'd4);
            et = trig_valid && (!host_valid || ptr_m) && (fifo_level < 3'd4);
            if (fifo_level == 3'd4) saw_full = 1'b1;
            check("host_ready", 64'(host_ready), 64'(eh));
            check("trig_ready", 64'(trig_ready), 64'(et));
            if (host_valid && host_ready) begin
                exp_q.push_back(hq.pop_front());
                order_q.push_back(1'b0);
                ptr_m = 1'b1;
            end else if (trig_valid && trig_ready) begin
                exp_q.push_back(tq.pop_front());
                order_q.push_back(1'b1);
                ptr_m = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        host_valid = 1'b0;
        trig_valid = 1'b0;
        check("run_within_budget", 64'(n < budget), 64'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_within_budget", 64'(n < budget), 64'd1);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        ptr_m = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int nr;
        rst_n = 1'b0;
        host_valid = 1'b0; host_addr = '0; host_wdata = '0;
        trig_valid = 1'b0; trig_addr = '0; trig_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_addr", 64'(ctrl_addr), 64'd0);
        check("rst_data", ctrl_wdata, 64'd0);
        check("rst_we", 64'(ctrl_write_enable), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_count", 64'(writes_issued), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single host write with exact cycle timing from the accepting edge E0.
        host_valid = 1'b1; host_addr = 8'h05; host_wdata = 64'hDEAD;
        #1 check("t1_host_ready", 64'(host_ready), 64'd1);
        exp_q.push_back('{a: 8'h05, d: 64'hDEAD});
        ptr_m = 1'b1;
        @(posedge clk); #1;
        host_valid = 1'b0;
        check("t1_E0_level", 64'(fifo_level), 64'd1);
        check("t1_E0_busy", 64'(busy), 64'd1);
        check("t1_E0_we", 64'(ctrl_write_enable), 64'd0);
        @(posedge clk); #1;
        check("t1_E1_addr", 64'(ctrl_addr), 64'h05);
        check("t1_E1_data", ctrl_wdata, 64'hDEAD);
        check("t1_E1_we", 64'(ctrl_write_enable), 64'd0);
        check("t1_E1_level", 64'(fifo_level), 64'd0);
        @(posedge clk); #1;
        check("t1_E2_we", 64'(ctrl_write_enable), 64'd1);
        check("t1_E2_count", 64'(writes_issued), 64'd1);
        @(posedge clk); #1;
        check("t1_E3_we", 64'(ctrl_write_enable), 64'd1);
        @(posedge clk); #1;
        check("t1_E4_we", 64'(ctrl_write_enable), 64'd0);
        check("t1_E4_addr_held", 64'(ctrl_addr), 64'h05);
        @(posedge clk); #1;
        check("t1_E5_we", 64'(ctrl_write_enable), 64'd0);
        check("t1_E5_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check("t1_E6_busy", 64'(busy), 64'd0);
        check("t1_E6_addr_kept", 64'(ctrl_addr), 64'h05);

        // Both requesters, four writes each: alternate H,T and strobe every 5 cycles.
        do_reset();
        order_q.delete();
        rise_cycles.delete();
        for (int i = 0; i < 4; i++) begin
            hq.push_back('{a: 8'h10 + 8'(i), d: 64'hA000 + 64'(i)});
            tq.push_back('{a: 8'h20 + 8'(i), d: 64'hB000 + 64'(i)});
        end
        run_streams(200);
        wait_idle(200);
        check("t2_order_len", 64'(order_q.size()), 64'd8);
        for (int i = 0; i < order_q.size(); i++) check("t2_order", 64'(order_q[i]), 64'(i % 2));
        check("t2_rises", 64'(rise_cycles.size()), 64'd8);
        for (int i = 1; i < rise_cycles.size(); i++)
            check("t2_spacing", 64'(rise_cycles[i] - rise_cycles[i-1]), 64'd5);
        check("t2_count", 64'(writes_issued), 64'd8);

        // Host burst of 6 fills the FIFO while strobing.
        saw_full = 1'b0;
        for (int i = 0; i < 6; i++) hq.push_back('{a: 8'h40 + 8'(i), d: 64'(32'($urandom))});
        @(negedge clk);
        run_streams(300);
        wait_idle(300);
        check("t3_saw_full", 64'(saw_full), 64'd1);
        check("t3_count", 64'(writes_issued), 64'd14);

        // Trig-only stream.
        for (int i = 0; i < 5; i++) tq.push_back('{a: 8'h80 + 8'(i), d: 64'hC0DE_0000 + 64'(i)});
        @(negedge clk);
        run_streams(300);
        wait_idle(300);
        check("t4_count", 64'(writes_issued), 64'd19);

        // Reset during STROBE with three writes still queued.
        do_reset();
        for (int i = 0; i < 4; i++) hq.push_back('{a: 8'h60 + 8'(i), d: 64'h600 + 64'(i)});
        run_streams(50);
        check("t5_in_strobe", 64'(ctrl_write_enable), 64'd1);
        check("t5_queued", 64'(fifo_level), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_we", 64'(ctrl_write_enable), 64'd0);
        check("t5_async_level", 64'(fifo_level), 64'd0);
        check("t5_async_count", 64'(writes_issued), 64'd0);
        exp_q.delete();
        ptr_m = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nr = rise_cycles.size();
        repeat (20) @(negedge clk);
        check("t5_no_strobes", 64'(rise_cycles.size()), 64'(nr));
        check("t5_level", 64'(fifo_level), 64'd0);
        check("t5_count", 64'(writes_issued), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);

        // Counter wrap.
        force dut.r_writes_issued = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.r_writes_issued;
        @(negedge clk);
        check("t6_preset", 64'(writes_issued), 64'hFFFF_FFFF);
        hq.push_back('{a: 8'hEE, d: 64'h1234_5678_9ABC_DEF0});
        run_streams(50);
        wait_idle(50);
        check("t6_wrap", 64'(writes_issued), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cms_ctrl_sequencer.md
Name: cms_ctrl_sequencer

Overview:
- Owns the monitoring system's control port (ctrl_addr / ctrl_wdata / ctrl_write_enable).
- Shares that port between two requesters: the host (PS via AXI GPIO) and the on-chip trigger unit. Arbitration is round-robin.
- Buffers accepted writes in a small FIFO.
- Replays each write as a clean edge-triggered strobe: address/data set up one cycle before the rising edge of write enable, held through a fixed gap after it.

Parameters:
CTRL_ADDR_WIDTH, 8, control address width
CTRL_DATA_WIDTH, 64, control data width
FIFO_DEPTH, 4, buffered writes; power of two, >=2
WE_HIGH_CYCLES, 2, cycles ctrl_write_enable is held high; >=1
WE_GAP_CYCLES, 2, low cycles after strobe with addr/data held; >=1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
host_valid  in  1  host write request
host_ready  out  1  host request accepted this cycle when valid&ready
host_addr  in  CTRL_ADDR_WIDTH  host control address
host_wdata  in  CTRL_DATA_WIDTH  host control data
trig_valid  in  1  trigger-unit write request
trig_ready  out  1  trigger request accepted when valid&ready
trig_addr  in  CTRL_ADDR_WIDTH  trigger control address
trig_wdata  in  CTRL_DATA_WIDTH  trigger control data
ctrl_addr  out  CTRL_ADDR_WIDTH  to monitoring system control address
ctrl_wdata  out  CTRL_DATA_WIDTH  to monitoring system control data
ctrl_write_enable  out  1  to monitoring system write strobe
busy  out  1  FIFO non-empty or FSM not IDLE
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
writes_issued  out  32  count of strobes issued

Behaviour:

Interface:
- One clock. Reset is asynchronous, active-low, on rst_n.
- All outputs are registered except host_ready/trig_ready.

Reset:
- ctrl_addr=0, ctrl_wdata=0, ctrl_write_enable=0, busy=0, fifo_level=0, writes_issued=0.
- FIFO emptied; FSM=IDLE; round-robin pointer=host.
- Assertion mid-strobe drops ctrl_write_enable asynchronously. Queued writes are discarded.

Arbitration (combinational ready):
- Only one requester valid: it is granted.
- Both valid: the requester indicated by the pointer is granted.
- <x>_ready = granted & !fifo_full. At most one ready per cycle.
- The pointer moves to the other requester only on an accepted handshake.
- A requester must hold valid/addr/data until accepted. Ready never depends on the other requester's data.
- Accepted {addr,data} is written to the FIFO on the same edge.

FIFO:
- Circular, FIFO_DEPTH entries.
- Simultaneous push and pop in one cycle is allowed; level is unchanged.
- Full: both readys low.
- Pointers wrap modulo FIFO_DEPTH.

FSM:
- IDLE: FIFO non-empty -> pop head into ctrl_addr/ctrl_wdata, go SETUP. Write enable stays 0.
- SETUP (1 cycle): write enable stays 0 -> STROBE.
- STROBE (WE_HIGH_CYCLES): write enable is 1. writes_issued increments on entry.
- GAP (WE_GAP_CYCLES): write enable is 0, addr/data held.
  - At end, FIFO non-empty -> pop and go SETUP.
  - Otherwise -> IDLE.
- ctrl_addr/ctrl_wdata change only on a pop. They keep their last value in IDLE.

Timing:
- Latency: handshake at edge E0 -> pop/addr valid at E1 -> write enable rises at E2 -> falls at E2+WE_HIGH_CYCLES.
- Back-to-back rising edges are spaced 1+WE_HIGH_CYCLES+WE_GAP_CYCLES cycles apart.
- A push into an empty FIFO while in IDLE is visible to the FSM on the next cycle, never the same cycle.
- writes_issued wraps from 0xFFFFFFFF to 0.

Test Plan:
- Single host write addr=0x05 data=0xDEAD at E0 -> ctrl_addr=0x05/ctrl_wdata=0xDEAD at E1; write enable high E2..E3, low E4..E5; writes_issued=1; busy returns 0 at E6.
- Host and trig both valid for 4 writes each -> accepted order H,T,H,T,H,T,H,T; strobe rising edges exactly 5 cycles apart; writes_issued=8.
- Host holds valid with 6 writes, FSM stalled in strobing -> 4 accepted plus pops; host_ready=0 whenever fifo_level=4; no write lost or duplicated; output order matches input order.
- Trig-only stream with host idle -> trig granted every acceptable cycle; pointer does not starve trig.
- rst_n asserted during STROBE with 3 queued -> write enable falls immediately (async); after release fifo_level=0, no further strobes, writes_issued=0.
- writes_issued preset via force to 0xFFFFFFFF, one write -> reads 0.
